// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch widths, reset PC default and fetch entry type
package riscv_pkg;

   localparam int          XLEN     = 32;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   // One buffered instruction word as handed to decode.
   typedef struct packed {
      logic [31:0] inst;
      logic        err;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory and decode-side signals of the fetch stage
interface fetch_stage_if
   import riscv_pkg::*;
#(
   parameter int XLEN = riscv_pkg::XLEN
) ();

   logic            imem_req_o;
   logic [XLEN-1:0] imem_addr_o;
   logic            imem_gnt_i;
   logic            imem_rvalid_i;
   logic [31:0]     imem_rdata_i;
   logic            imem_err_i;
   logic            redirect_i;
   logic [XLEN-1:0] redirect_pc_i;
   logic            fetch_valid_o;
   logic            fetch_ready_i;
   logic [31:0]     fetch_inst_o;
   logic [XLEN-1:0] fetch_pc_o;
   logic            fetch_err_o;

   // Fetch unit side.
   modport master (
      output imem_req_o, imem_addr_o, fetch_valid_o, fetch_inst_o, fetch_pc_o, fetch_err_o,
      input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, imem_err_i,
      input  redirect_i, redirect_pc_i, fetch_ready_i
   );

   // Memory / decode / redirect source side.
   modport slave (
      input  imem_req_o, imem_addr_o, fetch_valid_o, fetch_inst_o, fetch_pc_o, fetch_err_o,
      output imem_gnt_i, imem_rvalid_i, imem_rdata_i, imem_err_i,
      output redirect_i, redirect_pc_i, fetch_ready_i
   );

endinterface

// File: rtl/fetch_stage_fifo.sv
// rtl/fetch_stage_fifo.sv - fetch_fifo: prefetch buffer of {inst, err} with flush
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int  DEPTH = 2,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  fetch_entry_t wdata,
   input  logic         pop,
   input  logic         flush,
   output fetch_entry_t rdata,
   output logic         full,
   output logic         empty,
   output logic [CW-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fetch_entry_t         mem [DEPTH];
   logic [AW-1:0]        rd_ptr;
   logic [AW-1:0]        wr_ptr;
   logic [CW-1:0]        count_q;
   logic                 push_ok;
   logic                 pop_ok;

   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   // A full buffer still accepts a push when its head leaves in the same cycle.
   assign push_ok = push && (!full || pop);
   assign pop_ok  = pop && !empty;
   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem[rd_ptr];

   // Storage and pointers; flush wins over a simultaneous push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= next_ptr(wr_ptr);
         end
         if (pop_ok) rd_ptr <= next_ptr(rd_ptr);
         count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - sequential instruction fetch with prefetch buffer and redirect; FETCH_STALL_CNT_EN adds a decode-starvation counter
module fetch_stage
   import riscv_pkg::*;
#(
   parameter int              XLEN       = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC   = XLEN'(riscv_pkg::RESET_PC),
   parameter int              FIFO_DEPTH = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   fetch_stage_if.master     bus
`ifdef FETCH_STALL_CNT_EN
   ,
   output logic [31:0]       fetch_stall_cnt_o
`endif
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic            started_q;
   logic            pend_q;
   logic            stale_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] head_pc_q;
   logic [XLEN-1:0] pend_addr_q;
   logic [CW-1:0]   out_q;
   logic [7:0]      drop_q;

   logic            redirect;
   logic [XLEN-1:0] new_pc;
   logic [XLEN-1:0] addr;
   logic            pop;
   logic            credit;
   logic            req;
   logic            gnt;
   logic            rsp;
   logic            keep;
   fetch_entry_t    push_data;
   fetch_entry_t    head;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CW-1:0]   fifo_count;

   assign redirect = bus.redirect_i;
   assign new_pc   = {bus.redirect_pc_i[XLEN-1:2], 2'b00};
   // An un-granted request keeps its original address even after a redirect.
   assign addr     = pend_q ? pend_addr_q : pc_q;
   assign pop      = !fifo_empty && bus.fetch_ready_i && !redirect;
   // Words granted but not yet returned plus buffered words must leave room
   // for one more; the head leaving this cycle frees its slot already.
   assign credit   = ({1'b0, out_q} + {1'b0, fifo_count}) <
                     ((CW+1)'(FIFO_DEPTH) + (CW+1)'(pop));
   assign req      = pend_q || (started_q && credit && !(fifo_full && !pop));
   assign gnt      = req && bus.imem_gnt_i;
   assign rsp      = bus.imem_rvalid_i;
   assign keep     = rsp && (drop_q == '0) && !redirect;

   assign push_data.inst = bus.imem_rdata_i;
   assign push_data.err  = bus.imem_err_i;

   assign bus.imem_req_o    = req;
   assign bus.imem_addr_o   = addr;
   assign bus.fetch_valid_o = !fifo_empty;
   assign bus.fetch_inst_o  = head.inst;
   assign bus.fetch_err_o   = head.err;
   assign bus.fetch_pc_o    = head_pc_q;

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk_i),
      .rst_n (rst_i),
      .push  (keep),
      .wdata (push_data),
      .pop   (pop),
      .flush (redirect),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // PC generation, in-flight accounting and stale-response drop bookkeeping.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         started_q   <= 1'b0;
         pend_q      <= 1'b0;
         stale_q     <= 1'b0;
         pc_q        <= RESET_PC;
         head_pc_q   <= RESET_PC;
         pend_addr_q <= RESET_PC;
         out_q       <= '0;
         drop_q      <= '0;
      end else begin
         started_q   <= 1'b1;
         pend_q      <= req && !bus.imem_gnt_i;
         pend_addr_q <= addr;
         if (redirect) begin
            pc_q      <= new_pc;
            head_pc_q <= new_pc;
            out_q     <= '0;
            // Everything still in flight, including this cycle's grant and
            // minus this cycle's response, belongs to the old path.
            drop_q    <= drop_q + 8'(out_q) + 8'(gnt) - 8'(rsp);
            stale_q   <= req && !bus.imem_gnt_i;
         end else begin
            if (gnt && stale_q) stale_q <= 1'b0;
            if (gnt && !stale_q) pc_q <= pc_q + XLEN'(4);
            if (pop) head_pc_q <= head_pc_q + XLEN'(4);
            drop_q <= drop_q + 8'(gnt && stale_q) - 8'(rsp && (drop_q != '0));
            out_q  <= out_q + CW'(gnt && !stale_q) - CW'(keep);
         end
      end
   end

`ifdef FETCH_STALL_CNT_EN
   logic [31:0] stall_q;

   // Count cycles where decode waits on an empty buffer outside a redirect.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stall_q <= '0;
      end else if (bus.fetch_ready_i && fifo_empty && !redirect && (stall_q != 32'hFFFF_FFFF)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign fetch_stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage (FETCH_STALL_CNT_EN optional)
module tb_fetch_stage;
   import riscv_pkg::*;

   localparam int          DEPTH  = 2;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fetch_stage_if #(.XLEN(32)) bus ();
`ifdef FETCH_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   fetch_stage #(.XLEN(32), .RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus)
`ifdef FETCH_STALL_CNT_EN
      ,
      .fetch_stall_cnt_o (stall_cnt)
`endif
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } rsp_t;

   typedef struct {
      logic [31:0] rpc;
      logic [31:0] pc0;
      logic        err0;
      logic [31:0] pc1;
      logic        err1;
   } vec_t;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int pops  = 0;
   int ready_pct, gnt_pct, rv_pct;
   rsp_t        mq [$];
   logic [31:0] glog [$];
   logic [31:0] plog [$];
   logic        elog [$];
   logic [31:0] exp_pc;
   logic        last_valid, prev_pend, prev_redir;
   logic [31:0] prev_addr;
   longint      stall_model;

   function automatic logic [31:0] mem_inst(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   function automatic logic mem_err(input logic [31:0] a);
      return a[5:2] == 4'd2;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock cycle: sample at the falling edge, check, drive the next cycle.
   task automatic step(input logic rd, input logic [31:0] rpc);
      logic rdy;
      logic g;
      @(negedge clk);
      cyc++;
      last_valid = bus.fetch_valid_o;
      if (prev_redir) check("valid_after_redirect", bus.fetch_valid_o, 1'b0);
      rdy = ($urandom_range(99) < ready_pct);
      bus.fetch_ready_i = rdy;
      bus.redirect_i    = rd;
      bus.redirect_pc_i = rpc;
      if (bus.fetch_valid_o && rdy && !rd) begin
         check("pop_pc", bus.fetch_pc_o, exp_pc);
         check("pop_inst", bus.fetch_inst_o, mem_inst(exp_pc));
         check("pop_err", bus.fetch_err_o, mem_err(exp_pc));
         plog.push_back(bus.fetch_pc_o);
         elog.push_back(bus.fetch_err_o);
         exp_pc = exp_pc + 32'd4;
         pops++;
      end
      if (rd) exp_pc = rpc & ~32'd3;
      if (rdy && !bus.fetch_valid_o && !rd && stall_model < 64'hFFFF_FFFF) stall_model++;
      if (mq.size() > 0 && mq[0].due <= cyc && $urandom_range(99) < rv_pct) begin
         bus.imem_rvalid_i = 1'b1;
         bus.imem_rdata_i  = mem_inst(mq[0].addr);
         bus.imem_err_i    = mem_err(mq[0].addr);
         void'(mq.pop_front());
      end else begin
         bus.imem_rvalid_i = 1'b0;
         bus.imem_rdata_i  = $urandom;
         bus.imem_err_i    = 1'($urandom_range(1));
      end
      #1;
      if (prev_pend) begin
         check("req_hold", bus.imem_req_o, 1'b1);
         check("addr_hold", bus.imem_addr_o, prev_addr);
      end
      g = bus.imem_req_o && ($urandom_range(99) < gnt_pct);
      bus.imem_gnt_i = g;
      if (g) begin
         mq.push_back('{addr: bus.imem_addr_o, due: cyc + 1});
         glog.push_back(bus.imem_addr_o);
      end
      prev_pend  = bus.imem_req_o && !g;
      prev_addr  = bus.imem_addr_o;
      prev_redir = rd;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req"}, bus.imem_req_o, 1'b0);
      check({tag, "_addr"}, bus.imem_addr_o, RST_PC);
      check({tag, "_valid"}, bus.fetch_valid_o, 1'b0);
      check({tag, "_inst"}, bus.fetch_inst_o, 32'd0);
      check({tag, "_pc"}, bus.fetch_pc_o, RST_PC);
      check({tag, "_err"}, bus.fetch_err_o, 1'b0);
`ifdef FETCH_STALL_CNT_EN
      check({tag, "_stall_cnt"}, stall_cnt, 32'd0);
`endif
   endtask

   task automatic clear_inputs();
      bus.imem_gnt_i    = 1'b0;
      bus.imem_rvalid_i = 1'b0;
      bus.imem_rdata_i  = 32'd0;
      bus.imem_err_i    = 1'b0;
      bus.redirect_i    = 1'b0;
      bus.redirect_pc_i = 32'd0;
      bus.fetch_ready_i = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t vecs [3];
      int   first, bubbles, gi, pi, p0, in_sys;
      logic [31:0] held;

      vecs[0] = '{rpc: 32'h0000_0303, pc0: 32'h0000_0300, err0: 1'b0, pc1: 32'h0000_0304, err1: 1'b0};
      vecs[1] = '{rpc: 32'hFFFF_FFFE, pc0: 32'hFFFF_FFFC, err0: 1'b0, pc1: 32'h0000_0000, err1: 1'b0};
      vecs[2] = '{rpc: 32'h0000_000A, pc0: 32'h0000_0008, err0: 1'b1, pc1: 32'h0000_000C, err1: 1'b0};

      clear_inputs();
      ready_pct = 100; gnt_pct = 100; rv_pct = 100;
      prev_pend = 1'b0; prev_redir = 1'b0; prev_addr = '0;
      stall_model = 0;
      exp_pc = RST_PC;

      // Reset values.
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;

      // Streaming start-up: latency, addresses and no bubbles.
      first = -1; bubbles = 0;
      for (int i = 1; i <= 20; i++) begin
         step(1'b0, 32'd0);
         if (last_valid && first < 0) first = i;
         if (first > 0 && !last_valid) bubbles++;
      end
      check("first_valid_latency", first, 3);
      check("stream_bubbles", bubbles, 0);
      check("grant0", glog.size() > 0 ? glog[0] : 32'hDEAD_BEEF, 32'h0);
      check("grant1", glog.size() > 1 ? glog[1] : 32'hDEAD_BEEF, 32'h4);
      check("grant2", glog.size() > 2 ? glog[2] : 32'hDEAD_BEEF, 32'h8);
      check("err_pc8", (plog.size() > 2) ? {plog[2], 31'd0, elog[2]} : 64'd0, {32'h8, 32'd1});
      check("noerr_pcC", (plog.size() > 3) ? {plog[3], 31'd0, elog[3]} : 64'd0, {32'hC, 32'd0});

      // Decode stalled: credit limit holds and requests stop.
      ready_pct = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 32'd0);
         in_sys = glog.size() - pops;
         check("credit_limit", in_sys <= DEPTH, 1'b1);
      end
      check("req_dropped", bus.imem_req_o, 1'b0);
      check("in_sys_full", glog.size() - pops, DEPTH);
      ready_pct = 100;
      repeat (6) step(1'b0, 32'd0);

      // Redirect with two responses in flight.
      rv_pct = 0;
      repeat (4) step(1'b0, 32'd0);
      check("inflight_before_redirect", mq.size(), 2);
      gi = glog.size(); pi = plog.size();
      step(1'b1, 32'h0000_0100);
      rv_pct = 100;
      repeat (10) step(1'b0, 32'd0);
      check("addr_after_redirect", glog.size() > gi ? glog[gi] : 32'hDEAD_BEEF, 32'h100);
      check("pc_after_redirect", plog.size() > pi ? plog[pi] : 32'hDEAD_BEEF, 32'h100);

      // Redirect while a request waits for grant.
      gnt_pct = 0;
      step(1'b0, 32'd0);
      check("req_pending", bus.imem_req_o, 1'b1);
      held = bus.imem_addr_o;
      step(1'b0, 32'd0);
      gi = glog.size(); pi = plog.size();
      step(1'b1, 32'h0000_0200);
      repeat (3) step(1'b0, 32'd0);
      check("stale_addr_held", bus.imem_addr_o, held);
      gnt_pct = 100;
      repeat (10) step(1'b0, 32'd0);
      check("stale_grant_addr", glog.size() > gi ? glog[gi] : 32'hDEAD_BEEF, held);
      check("new_path_addr", glog.size() > gi + 1 ? glog[gi + 1] : 32'hDEAD_BEEF, 32'h200);
      check("new_path_pc", plog.size() > pi ? plog[pi] : 32'hDEAD_BEEF, 32'h200);

      // Redirect vectors: alignment, wrap-around, error word.
      for (int v = 0; v < 3; v++) begin
         pi = plog.size();
         step(1'b1, vecs[v].rpc);
         for (int k = 0; k < 20 && plog.size() < pi + 2; k++) step(1'b0, 32'd0);
         check("vec_pc0", plog.size() > pi ? plog[pi] : 32'hDEAD_BEEF, vecs[v].pc0);
         check("vec_err0", elog.size() > pi ? elog[pi] : 1'bx, vecs[v].err0);
         check("vec_pc1", plog.size() > pi + 1 ? plog[pi + 1] : 32'hDEAD_BEEF, vecs[v].pc1);
         check("vec_err1", elog.size() > pi + 1 ? elog[pi + 1] : 1'bx, vecs[v].err1);
      end

      // Random traffic against the delivery model.
      for (int i = 0; i < 2000; i++) begin
         if (i % 200 == 0) begin
            ready_pct = 30 + $urandom_range(70);
            gnt_pct   = 20 + $urandom_range(80);
            rv_pct    = 20 + $urandom_range(80);
         end
         if ($urandom_range(24) == 0) step(1'b1, $urandom & 32'h0000_FFFF);
         else step(1'b0, 32'd0);
      end
      ready_pct = 100; gnt_pct = 100; rv_pct = 100;
      p0 = pops;
      repeat (30) step(1'b0, 32'd0);
      check("progress", pops > p0 + 20, 1'b1);
`ifdef FETCH_STALL_CNT_EN
      check("stall_cnt", stall_cnt, stall_model[31:0]);
`endif

      // Asynchronous reset mid-stream.
      @(negedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      clear_inputs();
      mq.delete();
      prev_pend = 1'b0; prev_redir = 1'b0;
      stall_model = 0;
      exp_pc = RST_PC;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      gi = glog.size(); pi = plog.size();
      repeat (10) step(1'b0, 32'd0);
      check("restart_addr", glog.size() > gi ? glog[gi] : 32'hDEAD_BEEF, RST_PC);
      check("restart_pc", plog.size() > pi ? plog[pi] : 32'hDEAD_BEEF, RST_PC);
`ifdef FETCH_STALL_CNT_EN
      check("stall_cnt_restart", stall_cnt, stall_model[31:0]);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch unit sitting directly upstream of the decode stage in `core`.
- Generates sequential PCs and issues word requests on a req/gnt/rvalid instruction-memory port.
- Buffers returned words in a small prefetch FIFO and presents {inst, pc, err} to decode with a valid/ready handshake.
- Handles redirects (branch/jump/trap) by flushing buffered words and discarding stale in-flight responses.

Parameters:
- XLEN, 32, address/data width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, prefetch entries; also the maximum number of outstanding plus buffered words (credit limit).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  XLEN  word-aligned fetch address.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  response valid; responses return in order, earliest one cycle after gnt.
- imem_rdata_i  in  32  instruction word.
- imem_err_i  in  1  bus error, qualified by rvalid.
- redirect_i  in  1  flush and restart fetch.
- redirect_pc_i  in  XLEN  new PC; bits [1:0] ignored (forced 0).
- fetch_valid_o  out  1  head entry valid toward decode.
- fetch_ready_i  in  1  decode accepts the head entry.
- fetch_inst_o  out  32  instruction (becomes decode's dec_inst_i).
- fetch_pc_o  out  XLEN  PC of fetch_inst_o.
- fetch_err_o  out  1  head entry carries a bus error.

Behaviour:
- Reset (rst_i=0, async): pc_q=RESET_PC, head_pc_q=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0, stale=0.
  - Outputs: imem_req_o=0, imem_addr_o=RESET_PC, fetch_valid_o=0, fetch_inst_o=0, fetch_pc_o=RESET_PC, fetch_err_o=0.
  - Reset asserted mid-operation abandons all state; responses arriving after reset release are not expected (memory is reset together with the core).
- Request issue:
  - imem_req_o=1 when outstanding + fifo_count < FIFO_DEPTH, or when a request is already pending un-granted.
  - While imem_req_o=1 and imem_gnt_i=0, imem_addr_o and imem_req_o hold stable, even across a redirect.
  - On gnt: outstanding+1 and pc_q+=4 (wraps modulo 2^XLEN).
- Response:
  - On rvalid with drop_cnt>0: discard the word and decrement drop_cnt.
  - Otherwise push {rdata, err} into the FIFO and decrement outstanding.
  - The FIFO can never overflow because of the credit rule.
- Output:
  - FIFO head is registered; latency from imem_rvalid_i to fetch_valid_o is 1 cycle.
  - Pop when fetch_valid_o && fetch_ready_i, then head_pc_q+=4.
  - Push and pop in the same cycle are both allowed, including a push into a full FIFO that is popping.
- Redirect (highest priority):
  - FIFO cleared; pc_q and head_pc_q set to redirect_pc_i.
  - drop_cnt loaded with (outstanding + gnt_this_cycle − responses_consumed_this_cycle); a response arriving in the redirect cycle is also discarded.
  - If a request is pending un-granted, stale=1; that request's eventual gnt adds 1 to drop_cnt and clears stale.
  - A pop coinciding with redirect is ignored; decode squashes the word itself.
  - fetch_valid_o=0 in the cycle after redirect.
  - The first new-path request is issued the cycle after redirect (or after the stale grant).
  - Back-to-back redirects: each reloads the PCs; drop accounting accumulates.
- Errors: fetch_inst_o passes the raw rdata; fetch_err_o=1; decode raises the fault. Fetch continues sequentially.

Optional Feature:
- Macro FETCH_STALL_CNT_EN.
- Defined:
  - Adds output fetch_stall_cnt_o [31:0], reset 0.
  - Increments (saturating at 32'hFFFF_FFFF) each cycle fetch_ready_i=1 && fetch_valid_o=0 && redirect_i=0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package riscv_pkg holds XLEN, RESET_PC default, and a fetch-entry struct typedef {inst[31:0], err}.
- Sub-module fetch_fifo:
  - Parameterised depth; holds {inst, err}.
  - Signals: push, pop, flush, full, empty, count.
  - Flush takes priority over push in the same cycle.

Test Plan:
- Reset release, memory grants every cycle with 1-cycle rvalid, ready=1 → addresses 0x0, 0x4, 0x8…; fetch_pc_o 0x0, 0x4…; first fetch_valid_o 3 cycles after reset release; no bubbles.
- ready=0 held for 10 cycles → at most FIFO_DEPTH words outstanding or buffered; req drops; on ready=1 the words drain in order with correct PCs.
- Redirect to 0x100 with 2 responses in flight → both discarded; next request addr 0x100; first delivered fetch_pc_o=0x100.
- Redirect while req pending with gnt=0 for 3 cycles → addr unchanged until gnt; that response is dropped; next address 0x200 = redirect_pc_i.
- rvalid with err=1 at PC 0x8 → fetch_err_o=1 with fetch_pc_o=0x8; the following entry has fetch_err_o=0 and fetch_pc_o=0xC.
- rst_i pulsed low mid-stream → all outputs return to reset values asynchronously; fetch restarts at RESET_PC.
